// File: rtl/envase_pkg.sv
// Shared state codes and counting defaults for the bottle fill/seal line controller.
package envase_pkg;

    // Codes are fixed because estado drives the panel display directly.
    typedef enum logic [2:0] {
        PARADO  = 3'd0,
        ESTEIRA = 3'd1,
        ENCHE   = 3'd2,
        VEDA    = 3'd3,
        ALARME  = 3'd4
    } estado_t;

    localparam int DUZIA_PADRAO     = 12;
    localparam int DUZIA_MAX_PADRAO = 10;

endpackage

// File: rtl/modulo_estoque_rolhas.sv
// Two-level cork store: stock register fed by panel entries, dispenser register
// refilled from stock in lots and drained by one cork per sealed bottle.
module modulo_estoque_rolhas #(
    parameter int ROLHA_W   = 7,
    parameter int ROLHA_MAX = 99,
    parameter int ROLHA_MIN = 5,
    parameter int LOTE      = 20
) (
    input  logic               clk,
    input  logic               Nclr,
    input  logic               consume,
    input  logic               ent_valid,
    input  logic [ROLHA_W-1:0] ent_qtd,
    output logic [ROLHA_W-1:0] estoque,
    output logic [ROLHA_W-1:0] disp,
    output logic               ent_err
);

    logic [ROLHA_W-1:0] estoque_q, estoque_d;
    logic [ROLHA_W-1:0] disp_q, disp_d;
    logic               ent_err_q, ent_err_d;
    logic [ROLHA_W-1:0] lote_t;
    logic [ROLHA_W-1:0] restante;
    logic [ROLHA_W:0]   soma;
    logic               precisa;

    always_comb begin
        precisa = (disp_q < ROLHA_W'(ROLHA_MIN)) && (estoque_q != '0);
        lote_t  = '0;
        if (precisa) begin
            lote_t = (estoque_q < ROLHA_W'(LOTE)) ? estoque_q : ROLHA_W'(LOTE);
        end
        restante = estoque_q - lote_t;

        // An entry is judged against the stock left after this cycle's transfer.
        soma      = {1'b0, restante} + {1'b0, ent_qtd};
        estoque_d = restante;
        ent_err_d = 1'b0;
        if (ent_valid) begin
            if (soma <= (ROLHA_W+1)'(ROLHA_MAX)) begin
                estoque_d = soma[ROLHA_W-1:0];
            end else begin
                ent_err_d = 1'b1;
            end
        end

        disp_d = disp_q + lote_t - ROLHA_W'(consume);
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            estoque_q <= '0;
            disp_q    <= '0;
            ent_err_q <= 1'b0;
        end else begin
            estoque_q <= estoque_d;
            disp_q    <= disp_d;
            ent_err_q <= ent_err_d;
        end
    end

    assign estoque = estoque_q;
    assign disp    = disp_q;
    assign ent_err = ent_err_q;

endmodule

// File: rtl/modulo_envase_vedacao_param.sv
// Fill/seal line controller: conveyor/fill/seal FSM, bottle and dozen counters, cork store.
// Define ENVASE_WATCHDOG_EN to add the ENCHE/VEDA dwell watchdog.
module modulo_envase_vedacao_param
    import envase_pkg::*;
#(
    parameter int ROLHA_W   = 7,
    parameter int ROLHA_MAX = 99,
    parameter int ROLHA_MIN = 5,
    parameter int LOTE      = 20,
    parameter int DUZIA     = DUZIA_PADRAO,
    parameter int DUZIA_MAX = DUZIA_MAX_PADRAO
`ifdef ENVASE_WATCHDOG_EN
    ,parameter int WDOG_CYC = 255
`endif
) (
    input  logic                         clk,
    input  logic                         Nclr,
    input  logic                         start_stop,
    input  logic                         pg,
    input  logic                         ch,
    input  logic                         cq,
    input  logic                         ent_valid,
    input  logic [ROLHA_W-1:0]           ent_qtd,
    output logic                         ent_err,
    output logic                         m,
    output logic                         ev,
    output logic                         ve,
    output logic                         al,
    output logic [2:0]                   estado,
    output logic [ROLHA_W-1:0]           estoque,
    output logic [ROLHA_W-1:0]           disp,
    output logic [$clog2(DUZIA)-1:0]     cnt_garrafas,
    output logic [$clog2(DUZIA_MAX)-1:0] cnt_duzias
);

    localparam int CG_W = $clog2(DUZIA);
    localparam int CD_W = $clog2(DUZIA_MAX);

    estado_t           state_q, state_d;
    logic              ss_prev_q, ss_prev_d;
    logic              m_q, m_d, ev_q, ev_d, ve_q, ve_d, al_q, al_d;
    logic [CG_W-1:0]   cnt_g_q, cnt_g_d;
    logic [CD_W-1:0]   cnt_d_q, cnt_d_d;
    logic [ROLHA_W-1:0] disp_w;
    logic              consume;
    logic              ss_edge;

`ifdef ENVASE_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_flag_q, wdog_flag_d;
    logic              wdog_hit;
`endif

    modulo_estoque_rolhas #(
        .ROLHA_W   (ROLHA_W),
        .ROLHA_MAX (ROLHA_MAX),
        .ROLHA_MIN (ROLHA_MIN),
        .LOTE      (LOTE)
    ) u_estoque (
        .clk       (clk),
        .Nclr      (Nclr),
        .consume   (consume),
        .ent_valid (ent_valid),
        .ent_qtd   (ent_qtd),
        .estoque   (estoque),
        .disp      (disp_w),
        .ent_err   (ent_err)
    );

    // A stop request blocks the seal, so no cork is used and no bottle counted.
    assign consume   = (state_q == VEDA) && start_stop && cq;
    assign ss_edge   = start_stop && !ss_prev_q;
    assign ss_prev_d = start_stop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            PARADO:  state_d = ESTEIRA;
            ESTEIRA: if (pg) state_d = ENCHE;
            ENCHE:   if (ch) state_d = (disp_w == '0) ? ALARME : VEDA;
            VEDA:    if (cq) state_d = ESTEIRA;
            ALARME: begin
`ifdef ENVASE_WATCHDOG_EN
                if ((disp_w != '0) && !wdog_flag_q) state_d = VEDA;
`else
                if (disp_w != '0) state_d = VEDA;
`endif
            end
            default: state_d = PARADO;
        endcase
`ifdef ENVASE_WATCHDOG_EN
        if (wdog_hit) state_d = ALARME;
`endif
        if (!start_stop) state_d = PARADO;

        m_d  = (state_d == ESTEIRA);
        ev_d = (state_d == ENCHE);
        ve_d = (state_d == VEDA);
        al_d = (state_d == ALARME);
    end

    always_comb begin
        cnt_g_d = cnt_g_q;
        cnt_d_d = cnt_d_q;
        if (ss_edge) begin
            cnt_g_d = '0;
            cnt_d_d = '0;
        end else if (consume) begin
            if (cnt_g_q == CG_W'(DUZIA - 1)) begin
                cnt_g_d = '0;
                cnt_d_d = (cnt_d_q == CD_W'(DUZIA_MAX - 1)) ? '0 : cnt_d_q + CD_W'(1);
            end else begin
                cnt_g_d = cnt_g_q + CG_W'(1);
            end
        end
    end

`ifdef ENVASE_WATCHDOG_EN
    // The dwell counter restarts on every state change; a watchdog alarm latches until stop.
    always_comb begin
        wdog_hit = ((state_q == ENCHE) || (state_q == VEDA)) &&
                   (wdog_cnt_q == WDOG_W'(WDOG_CYC - 1));
        if (state_d != state_q) begin
            wdog_cnt_d = '0;
        end else if ((state_q == ENCHE) || (state_q == VEDA)) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end else begin
            wdog_cnt_d = '0;
        end
        if (state_d == PARADO) begin
            wdog_flag_d = 1'b0;
        end else if (wdog_hit) begin
            wdog_flag_d = 1'b1;
        end else begin
            wdog_flag_d = wdog_flag_q;
        end
    end

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            wdog_cnt_q  <= '0;
            wdog_flag_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_flag_q <= wdog_flag_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            state_q   <= PARADO;
            ss_prev_q <= 1'b0;
            m_q       <= 1'b0;
            ev_q      <= 1'b0;
            ve_q      <= 1'b0;
            al_q      <= 1'b0;
            cnt_g_q   <= '0;
            cnt_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            ss_prev_q <= ss_prev_d;
            m_q       <= m_d;
            ev_q      <= ev_d;
            ve_q      <= ve_d;
            al_q      <= al_d;
            cnt_g_q   <= cnt_g_d;
            cnt_d_q   <= cnt_d_d;
        end
    end

    assign m            = m_q;
    assign ev           = ev_q;
    assign ve           = ve_q;
    assign al           = al_q;
    assign estado       = state_q;
    assign disp         = disp_w;
    assign cnt_garrafas = cnt_g_q;
    assign cnt_duzias   = cnt_d_q;

endmodule

// File: tb/tb_modulo_envase_vedacao_param.sv
// Self-checking bench for modulo_envase_vedacao_param: a cycle model feeds a
// scoreboard queue, and each scenario task adds its own directed checks.
`timescale 1ns/1ps
module tb_modulo_envase_vedacao_param;

    localparam int MAXR = 99;
    localparam int MINR = 5;
    localparam int LOTE = 20;
    localparam int DUZ  = 12;
    localparam int DUZM = 10;

    localparam int S_PARADO  = 0;
    localparam int S_ESTEIRA = 1;
    localparam int S_ENCHE   = 2;
    localparam int S_VEDA    = 3;
    localparam int S_ALARME  = 4;

    logic       clk = 1'b0;
    logic       Nclr;
    logic       start_stop, pg, ch, cq, ent_valid;
    logic [6:0] ent_qtd;
    logic       ent_err, m, ev, ve, al;
    logic [2:0] estado;
    logic [6:0] estoque, disp;
    logic [3:0] cnt_garrafas, cnt_duzias;

    int checks = 0;
    int errors = 0;

    // Model state
    int ms, md, me, merr, mcg, mcd, bottles;
    bit mprev;

    logic [29:0] fila[$];
    logic [29:0] mon_exp;
    logic [29:0] dut_vec;

    assign dut_vec = {estado, m, ev, ve, al, estoque, disp, ent_err, cnt_garrafas, cnt_duzias};

    modulo_envase_vedacao_param dut (
        .clk          (clk),
        .Nclr         (Nclr),
        .start_stop   (start_stop),
        .pg           (pg),
        .ch           (ch),
        .cq           (cq),
        .ent_valid    (ent_valid),
        .ent_qtd      (ent_qtd),
        .ent_err      (ent_err),
        .m            (m),
        .ev           (ev),
        .ve           (ve),
        .al           (al),
        .estado       (estado),
        .estoque      (estoque),
        .disp         (disp),
        .cnt_garrafas (cnt_garrafas),
        .cnt_duzias   (cnt_duzias)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] pack_exp(int st, int e, int d, int err, int cg, int cd);
        logic [2:0] s3;
        logic [6:0] e7, d7;
        logic [3:0] g4, z4;
        s3 = 3'(st);
        e7 = 7'(e);
        d7 = 7'(d);
        g4 = 4'(cg);
        z4 = 4'(cd);
        return {s3, (st == S_ESTEIRA), (st == S_ENCHE), (st == S_VEDA), (st == S_ALARME),
                e7, d7, (err != 0), g4, z4};
    endfunction

    // One clock of the line as the operator would describe it.
    function automatic void model_step();
        int t, nd, ne, ns, cons;
        t = 0;
        if (md < MINR && me > 0) t = (me < LOTE) ? me : LOTE;
        cons = (ms == S_VEDA && start_stop === 1'b1 && cq === 1'b1) ? 1 : 0;
        ne = me - t;
        merr = 0;
        if (ent_valid === 1'b1) begin
            if (ne + int'(ent_qtd) <= MAXR) ne = ne + int'(ent_qtd);
            else merr = 1;
        end
        nd = md + t - cons;
        if (start_stop !== 1'b1) ns = S_PARADO;
        else begin
            case (ms)
                S_PARADO:  ns = S_ESTEIRA;
                S_ESTEIRA: ns = (pg === 1'b1) ? S_ENCHE : S_ESTEIRA;
                S_ENCHE:   ns = (ch === 1'b1) ? ((md == 0) ? S_ALARME : S_VEDA) : S_ENCHE;
                S_VEDA:    ns = (cq === 1'b1) ? S_ESTEIRA : S_VEDA;
                S_ALARME:  ns = (md > 0) ? S_VEDA : S_ALARME;
                default:   ns = S_PARADO;
            endcase
        end
        if (cons == 1) bottles++;
        if (start_stop === 1'b1 && !mprev) begin
            mcg = 0;
            mcd = 0;
        end else if (cons == 1) begin
            mcg = mcg + 1;
            if (mcg == DUZ) begin
                mcg = 0;
                mcd = (mcd + 1) % DUZM;
            end
        end
        mprev = (start_stop === 1'b1);
        ms = ns;
        md = nd;
        me = ne;
    endfunction

    task automatic step();
        logic [29:0] e;
        model_step();
        e = pack_exp(ms, me, md, merr, mcg, mcd);
        @(posedge clk);
        fila.push_back(e);
        #1;
    endtask

    task automatic model_reset();
        ms = S_PARADO; md = 0; me = 0; merr = 0; mcg = 0; mcd = 0; bottles = 0;
        mprev = 1'b0;
        fila.delete();
    endtask

    task automatic clear_inputs();
        start_stop = 1'b0; pg = 1'b0; ch = 1'b0; cq = 1'b0;
        ent_valid = 1'b0; ent_qtd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        Nclr = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #2;
        Nclr = 1'b1;
    endtask

    task automatic entry(input int q);
        ent_valid = 1'b1;
        ent_qtd   = 7'(q);
        step();
        ent_valid = 1'b0;
        ent_qtd   = '0;
    endtask

    // Scoreboard: every modelled edge is compared on the following falling edge.
    always @(negedge clk) begin
        if (Nclr === 1'b1 && fila.size() > 0) begin
            mon_exp = fila.pop_front();
            checks++;
            if (dut_vec !== mon_exp) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got=%h expected=%h", $time, dut_vec, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic test_reset();
        Nclr = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        checks++;
        if (dut_vec !== 30'd0) begin
            errors++;
            $display("[TB] FAIL power_on_reset got=%h expected=0", dut_vec);
        end
        @(posedge clk);
        #2;
        Nclr = 1'b1;

        start_stop = 1'b1;
        entry(30);
        pg = 1'b1;
        step();
        pg = 1'b0;
        step();
        checks++;
        if (estado !== 3'd2 || ev !== 1'b1 || disp !== 7'd20 || estoque !== 7'd10) begin
            errors++;
            $display("[TB] FAIL pre_reset_enche estado=%0d ev=%b disp=%0d estoque=%0d expected 2/1/20/10",
                     estado, ev, disp, estoque);
        end
        @(negedge clk);
        #2;
        Nclr = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== 30'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_mid_enche got=%h expected=0", dut_vec);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== 30'd0 || ent_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held_edge got=%h expected=0", dut_vec);
        end
    endtask

    task automatic test_entrada();
        do_reset();
        entry(25);
        step();
        entry(55);
        checks++;
        if (estoque !== 7'd60 || disp !== 7'd20) begin
            errors++;
            $display("[TB] FAIL entry_60 estoque=%0d disp=%0d expected 60/20", estoque, disp);
        end
        entry(50);
        checks++;
        if (ent_err !== 1'b1 || estoque !== 7'd60) begin
            errors++;
            $display("[TB] FAIL entry_reject ent_err=%b estoque=%0d expected 1/60", ent_err, estoque);
        end
        step();
        checks++;
        if (ent_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ent_err_pulse ent_err=%b expected 0", ent_err);
        end
        entry(39);
        checks++;
        if (estoque !== 7'd99 || ent_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL entry_to_max estoque=%0d ent_err=%b expected 99/0", estoque, ent_err);
        end
        entry(1);
        checks++;
        if (ent_err !== 1'b1 || estoque !== 7'd99) begin
            errors++;
            $display("[TB] FAIL entry_over_max ent_err=%b estoque=%0d expected 1/99", ent_err, estoque);
        end
    endtask

    task automatic test_transferencia();
        int n;
        do_reset();
        entry(45);
        step();
        checks++;
        if (disp !== 7'd20 || estoque !== 7'd25) begin
            errors++;
            $display("[TB] FAIL first_lot disp=%0d estoque=%0d expected 20/25", disp, estoque);
        end
        step();
        checks++;
        if (disp !== 7'd20 || estoque !== 7'd25) begin
            errors++;
            $display("[TB] FAIL no_extra_lot disp=%0d estoque=%0d expected 20/25", disp, estoque);
        end
        start_stop = 1'b1; pg = 1'b1; ch = 1'b1; cq = 1'b1;
        n = 0;
        while (md != 24 && n < 300) begin step(); n++; end
        checks++;
        if (n >= 300 || disp !== 7'd24 || estoque !== 7'd5) begin
            errors++;
            $display("[TB] FAIL refill_at_4 disp=%0d estoque=%0d expected 24/5", disp, estoque);
        end
        n = 0;
        while (!(md == 9 && me == 0) && n < 300) begin step(); n++; end
        checks++;
        if (n >= 300 || disp !== 7'd9 || estoque !== 7'd0) begin
            errors++;
            $display("[TB] FAIL partial_lot disp=%0d estoque=%0d expected 9/0", disp, estoque);
        end
    endtask

    task automatic test_ciclo();
        do_reset();
        entry(1);
        step();
        checks++;
        if (disp !== 7'd1 || estoque !== 7'd0) begin
            errors++;
            $display("[TB] FAIL setup_one_cork disp=%0d estoque=%0d expected 1/0", disp, estoque);
        end
        start_stop = 1'b1;
        step();
        pg = 1'b1; step();
        pg = 1'b0; ch = 1'b1; step();
        ch = 1'b0; cq = 1'b1; step();
        checks++;
        if (disp !== 7'd0 || cnt_garrafas !== 4'd1 || estado !== 3'd1 || m !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_cycle disp=%0d cnt=%0d estado=%0d m=%b expected 0/1/1/1",
                     disp, cnt_garrafas, estado, m);
        end
        cq = 1'b0; pg = 1'b1; step();
        pg = 1'b0; ch = 1'b1; step();
        checks++;
        if (estado !== 3'd4 || al !== 1'b1 || ev !== 1'b0) begin
            errors++;
            $display("[TB] FAIL alarm_empty estado=%0d al=%b ev=%b expected 4/1/0", estado, al, ev);
        end
        ch = 1'b0;
        entry(10);
        step();
        checks++;
        if (disp !== 7'd10 || estoque !== 7'd0 || estado !== 3'd4) begin
            errors++;
            $display("[TB] FAIL alarm_refill disp=%0d estoque=%0d estado=%0d expected 10/0/4",
                     disp, estoque, estado);
        end
        step();
        checks++;
        if (estado !== 3'd3 || ve !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alarm_exit estado=%0d ve=%b expected 3/1", estado, ve);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        entry(90);
        entry(25);
        checks++;
        if (estoque !== 7'd95 || disp !== 7'd20 || ent_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL entry_with_lot estoque=%0d disp=%0d ent_err=%b expected 95/20/0",
                     estoque, disp, ent_err);
        end
        do_reset();
        entry(1);
        step();
        start_stop = 1'b1; step();
        pg = 1'b1; step();
        pg = 1'b0; ch = 1'b1;
        entry(30);
        ch = 1'b0; cq = 1'b1;
        entry(89);
        checks++;
        if (disp !== 7'd20 || estoque !== 7'd99 || ent_err !== 1'b0 || cnt_garrafas !== 4'd1) begin
            errors++;
            $display("[TB] FAIL lot_seal_entry disp=%0d estoque=%0d ent_err=%b cnt=%0d expected 20/99/0/1",
                     disp, estoque, ent_err, cnt_garrafas);
        end
    endtask

    task automatic test_contagem();
        int n;
        do_reset();
        pg = 1'b1; ch = 1'b1; cq = 1'b1;
        ent_valid = 1'b1; ent_qtd = 7'd20;
        step();
        start_stop = 1'b1;
        n = 0;
        while (bottles < 12 && n < 3000) begin step(); n++; end
        checks++;
        if (n >= 3000 || cnt_garrafas !== 4'd0 || cnt_duzias !== 4'd1) begin
            errors++;
            $display("[TB] FAIL first_dozen cnt_g=%0d cnt_d=%0d expected 0/1", cnt_garrafas, cnt_duzias);
        end
        while (bottles < 13 && n < 3000) begin step(); n++; end
        start_stop = 1'b0;
        step();
        checks++;
        if (estado !== 3'd0 || cnt_garrafas !== 4'd1 || cnt_duzias !== 4'd1) begin
            errors++;
            $display("[TB] FAIL stop_holds estado=%0d cnt_g=%0d cnt_d=%0d expected 0/1/1",
                     estado, cnt_garrafas, cnt_duzias);
        end
        start_stop = 1'b1;
        step();
        checks++;
        if (estado !== 3'd1 || cnt_garrafas !== 4'd0 || cnt_duzias !== 4'd0) begin
            errors++;
            $display("[TB] FAIL start_clears estado=%0d cnt_g=%0d cnt_d=%0d expected 1/0/0",
                     estado, cnt_garrafas, cnt_duzias);
        end
        bottles = 0;
        n = 0;
        while (bottles < 119 && n < 3000) begin step(); n++; end
        checks++;
        if (n >= 3000 || cnt_garrafas !== 4'd11 || cnt_duzias !== 4'd9) begin
            errors++;
            $display("[TB] FAIL bottle_119 cnt_g=%0d cnt_d=%0d expected 11/9", cnt_garrafas, cnt_duzias);
        end
        while (bottles < 120 && n < 3000) begin step(); n++; end
        checks++;
        if (n >= 3000 || cnt_garrafas !== 4'd0 || cnt_duzias !== 4'd0) begin
            errors++;
            $display("[TB] FAIL dozen_wrap cnt_g=%0d cnt_d=%0d expected 0/0", cnt_garrafas, cnt_duzias);
        end
        clear_inputs();
    endtask

`ifdef ENVASE_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        entry(30);
        step();
        start_stop = 1'b1; step();
        pg = 1'b1; step();
        pg = 1'b0;
        repeat (250) begin @(posedge clk); #1; end
        checks++;
        if (estado !== 3'd2) begin
            errors++;
            $display("[TB] FAIL wdog_not_yet estado=%0d expected 2", estado);
        end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (estado !== 3'd4 || al !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wdog_alarm estado=%0d al=%b expected 4/1", estado, al);
        end
        ch = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (estado !== 3'd4) begin
            errors++;
            $display("[TB] FAIL wdog_latched estado=%0d expected 4", estado);
        end
        start_stop = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (estado !== 3'd0 || al !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wdog_stop estado=%0d al=%b expected 0/0", estado, al);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting modulo_envase_vedacao_param bench");
        test_reset();
        test_entrada();
        test_transferencia();
        test_ciclo();
        test_back_to_back();
        test_contagem();
`ifdef ENVASE_WATCHDOG_EN
        test_watchdog();
`endif
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
